// File: rtl/wb_framer_pkg.sv
// Shared constants and state encodings for the Wishbone byte framer.
//   CMD_SYNC_DEFAULT / RSP_SYNC_DEFAULT : default frame marker bytes
//   FRAME_BODY_BYTES                    : bytes following the marker in every frame
//   rx_state_e / tx_state_e             : parser and serializer state encodings
package wb_framer_pkg;

    localparam logic [7:0]  CMD_SYNC_DEFAULT = 8'hCD;
    localparam logic [7:0]  RSP_SYNC_DEFAULT = 8'hDC;
    localparam int unsigned FRAME_BODY_BYTES = 12;
    localparam int unsigned FRAME_BODY_BITS  = FRAME_BODY_BYTES * 8;
    localparam logic [3:0]  LAST_BODY_IDX    = 4'(FRAME_BODY_BYTES - 1);

    typedef enum logic [1:0] {
        RxSync,
        RxBody,
        RxIssue
    } rx_state_e;

    typedef enum logic [1:0] {
        TxIdle,
        TxMark,
        TxBody
    } tx_state_e;

endpackage

// File: rtl/response_serializer.sv
// Captures one master response and serializes it as a framed byte stream:
// marker byte, then status, address, data, each MSB first.
//   out_en/out_status/out_address/out_data : single-cycle response from the master
//   out_ready                              : high while idle (a response can be captured)
//   tx_byte/tx_valid/tx_ready              : byte stream to the host, valid/ready handshake
module response_serializer
    import wb_framer_pkg::*;
#(
    parameter logic [7:0] RSP_SYNC = RSP_SYNC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        out_en,
    input  logic [31:0] out_status,
    input  logic [31:0] out_address,
    input  logic [31:0] out_data,
    output logic        out_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready
);

    tx_state_e                  state_q, state_d;
    logic [FRAME_BODY_BITS-1:0] rsp_q, rsp_d;
    logic [3:0]                 idx_q, idx_d;
    logic [7:0]                 byte_q, byte_d;
    logic [3:0]                 sel;
    logic [7:0]                 body_byte;
    logic                       take;

    assign tx_valid  = (state_q != TxIdle);
    assign out_ready = (state_q == TxIdle);
    assign tx_byte   = byte_q;
    assign take      = tx_valid & tx_ready;

    // Index of the byte to present after the current one is taken; clamped so the
    // part-select never leaves the capture register on the final byte.
    always_comb begin
        sel = 4'd0;
        if (state_q == TxBody && idx_q != LAST_BODY_IDX) begin
            sel = idx_q + 4'd1;
        end
    end

    assign body_byte = rsp_q[(FRAME_BODY_BYTES - 1 - int'(sel)) * 8 +: 8];

    always_comb begin
        state_d = state_q;
        rsp_d   = rsp_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        unique case (state_q)
            TxIdle: begin
                if (out_en) begin
                    rsp_d   = {out_status, out_address, out_data};
                    byte_d  = RSP_SYNC;
                    state_d = TxMark;
                end
            end
            TxMark: begin
                if (take) begin
                    idx_d   = 4'd0;
                    byte_d  = body_byte;
                    state_d = TxBody;
                end
            end
            TxBody: begin
                if (take) begin
                    if (idx_q == LAST_BODY_IDX) begin
                        idx_d   = 4'd0;
                        byte_d  = 8'h00;
                        state_d = TxIdle;
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        byte_d = body_byte;
                    end
                end
            end
            default: state_d = TxIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TxIdle;
            rsp_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
        end
    end

endmodule

// File: rtl/wishbone_byte_framer.sv
// Byte-stream front end for wishbone_master. Parses marker-led 12-byte command frames
// from the host link into a one-cycle command strobe, and serializes master responses
// back to the host through response_serializer.
//   rx_byte/rx_valid/rx_ready       : host command bytes, valid/ready handshake
//   master_ready/in_ready           : master can take a command / one-cycle command strobe
//   in_command/in_address/in_data   : last parsed command words, held until the next frame
//   out_en/out_*/out_ready          : master response capture
//   tx_byte/tx_valid/tx_ready       : response bytes to the host
//   frame_error                     : one-cycle pulse when a partial frame times out
module wishbone_byte_framer
    import wb_framer_pkg::*;
#(
    parameter int unsigned IDLE_TIMEOUT = 1000,
    parameter logic [7:0]  CMD_SYNC     = CMD_SYNC_DEFAULT,
    parameter logic [7:0]  RSP_SYNC     = RSP_SYNC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        master_ready,
    output logic        in_ready,
    output logic [31:0] in_command,
    output logic [31:0] in_address,
    output logic [31:0] in_data,
    input  logic        out_en,
    input  logic [31:0] out_status,
    input  logic [31:0] out_address,
    input  logic [31:0] out_data,
    output logic        out_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        frame_error
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(IDLE_TIMEOUT - 1);

    rx_state_e                  rx_state_q, rx_state_d;
    logic [3:0]                 count_q, count_d;
    logic [FRAME_BODY_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BODY_BITS-1:0] words_q, words_d;
    logic [FRAME_BODY_BITS-1:0] shifted;
    logic [15:0]                idle_q, idle_d;
    logic                       accept;

    assign rx_ready   = (rx_state_q != RxIssue);
    assign accept     = rx_valid & rx_ready;
    assign shifted    = {shift_q[FRAME_BODY_BITS-9:0], rx_byte};
    assign in_command = words_q[95:64];
    assign in_address = words_q[63:32];
    assign in_data    = words_q[31:0];

    always_comb begin
        rx_state_d  = rx_state_q;
        count_d     = count_q;
        shift_d     = shift_q;
        words_d     = words_q;
        idle_d      = idle_q;
        in_ready    = 1'b0;
        frame_error = 1'b0;
        unique case (rx_state_q)
            RxSync: begin
                idle_d = '0;
                if (accept && rx_byte == CMD_SYNC) begin
                    count_d    = 4'd0;
                    rx_state_d = RxBody;
                end
            end
            RxBody: begin
                // An accepted byte beats a timeout landing on the same cycle.
                if (accept) begin
                    shift_d = shifted;
                    count_d = count_q + 4'd1;
                    idle_d  = '0;
                    if (count_q == LAST_BODY_IDX) begin
                        words_d    = shifted;
                        rx_state_d = RxIssue;
                    end
                end else if (idle_q == TIMEOUT_LAST) begin
                    frame_error = 1'b1;
                    idle_d      = '0;
                    rx_state_d  = RxSync;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
            RxIssue: begin
                idle_d = '0;
                if (master_ready) begin
                    in_ready   = 1'b1;
                    rx_state_d = RxSync;
                end
            end
            default: rx_state_d = RxSync;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RxSync;
            count_q    <= '0;
            shift_q    <= '0;
            words_q    <= '0;
            idle_q     <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            words_q    <= words_d;
            idle_q     <= idle_d;
        end
    end

    response_serializer #(
        .RSP_SYNC (RSP_SYNC)
    ) u_response_serializer (
        .clk         (clk),
        .rst         (rst),
        .out_en      (out_en),
        .out_status  (out_status),
        .out_address (out_address),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

endmodule

// File: doc/wishbone_byte_framer.md
# wishbone_byte_framer

Byte-stream front end for `wishbone_master`. Parses framed command packets from an 8-bit host link (UART/FIFO side) into the master's `in_command`/`in_address`/`in_data` handshake. Serializes the master's `out_status`/`out_address`/`out_data` responses back into framed bytes. Sits directly upstream and downstream of `wishbone_master`, replacing the testbench file stimulus in hardware builds.

## Interface
Parameters:
- `IDLE_TIMEOUT`, 1000: cycles without an accepted byte, mid-frame, before the partial frame is dropped; legal range 2..65535.
- `CMD_SYNC`, 8'hCD: command frame marker byte.
- `RSP_SYNC`, 8'hDC: response frame marker byte.

Ports:
- Clock and reset: single clock `clk`; reset `rst` is asynchronous and active-high.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous active-high reset.
- `rx_byte` in 8: host command byte.
- `rx_valid` in 1: `rx_byte` valid.
- `rx_ready` out 1: framer accepts the byte this cycle.
- `master_ready` in 1: master can take a command.
- `in_ready` out 1: one-cycle command strobe to master.
- `in_command` out 32: command word.
- `in_address` out 32: address word.
- `in_data` out 32: data word.
- `out_en` in 1: master response valid; single-cycle.
- `out_status` in 32: response status.
- `out_address` in 32: response address.
- `out_data` in 32: response data.
- `out_ready` out 1: framer can accept a response.
- `tx_byte` out 8: response byte to host.
- `tx_valid` out 1: `tx_byte` valid.
- `tx_ready` in 1: host accepts the byte.
- `frame_error` out 1: one-cycle pulse when a partial frame is dropped.

## Operation
- **Frame format:** marker byte, then 12 body bytes. Body order is command, address, data, each 32-bit word MSB first.
- **RX FSM states:** `RX_SYNC`, `RX_BODY`, `RX_ISSUE`. A byte is accepted when `rx_valid & rx_ready`.
  - `RX_SYNC`: non-marker bytes are accepted and discarded. Accepting `CMD_SYNC` clears the 4-bit body count and moves to `RX_BODY`.
  - `RX_BODY`: each accepted byte shifts into a 96-bit shift register and increments the count. Accepting the 12th byte (count 11) moves to `RX_ISSUE`. Marker-valued bytes here are data, not resync.
  - `RX_ISSUE`: `rx_ready`=0. The shift register is copied to `in_command`/`in_address`/`in_data` on entry. `in_ready` is asserted for exactly one cycle, the first cycle in this state with `master_ready`=1, then the FSM returns to `RX_SYNC`.
- `rx_ready` = 1 in `RX_SYNC` and `RX_BODY`.
- `in_*` words hold their value until the next frame enters `RX_ISSUE`.
- **Idle timeout:** the counter clears on every accepted byte and on every state change, and increments in `RX_BODY` otherwise. When it reaches `IDLE_TIMEOUT-1`, the FSM goes to `RX_SYNC` and `frame_error` pulses. `RX_SYNC` and `RX_ISSUE` never time out.
- **TX FSM states:** `TX_IDLE`, `TX_MARK`, `TX_BODY`.
  - `TX_IDLE`: `out_ready`=1. On `out_en`, status/address/data are captured into a 96-bit register and the FSM moves to `TX_MARK`.
  - `TX_MARK`: presents `RSP_SYNC`.
  - `TX_BODY`: presents 12 bytes, MSB of status first.
  - The FSM advances one byte per `tx_valid & tx_ready`. After the 12th byte is accepted it returns to `TX_IDLE`.
- `out_en` while `out_ready`=0 is ignored; the response is lost, and the master is responsible for not doing this.
- RX and TX FSMs are independent; a new command may be parsed while a response drains.

## Timing
- **Reset values:** RX FSM in `RX_SYNC`, TX FSM in `TX_IDLE`. `rx_ready`=1, `out_ready`=1, and all other outputs 0.
- **Reset mid-operation:** any frame in progress is discarded on either side, with no `frame_error`.
- **Command latency:** 12th body byte accepted on cycle N → `in_ready` high on cycle N+1 if `master_ready` was high. Otherwise `in_ready` is delayed until the first cycle `master_ready` is high.
- **Response latency:** `out_en` on cycle N → `tx_valid`=1 with `tx_byte`=`RSP_SYNC` on cycle N+1. `out_ready`=0 from N+1 until the cycle after the last byte is accepted.
- **Output stability:** `tx_byte` is registered and stable while `tx_valid`=1 and `tx_ready`=0.
- **Throughput:** with `tx_ready` held high, one response takes 13 cycles.
- **Timeout boundary:** with no accepted byte after cycle N in `RX_BODY`, `frame_error` pulses on cycle N+`IDLE_TIMEOUT`.
- **Simultaneous events:** a byte accepted on the same cycle the timeout would fire wins; the counter clears.

## Structure
- **Package `wb_framer_pkg`:**
  - `CMD_SYNC_DEFAULT`, `RSP_SYNC_DEFAULT`.
  - `FRAME_BODY_BYTES`=12.
  - RX and TX state encodings.
- **Sub-module `response_serializer`:** the TX FSM plus the 96-bit capture register and its byte mux, instanced once.
- **Top level:** RX parsing and the timeout counter.

## Test plan
- **Single command:** bytes CD 00000001 00000000 00000005 with `master_ready`=1 → one-cycle `in_ready` on the cycle after the last byte. `in_command`=00000001, `in_address`=0, `in_data`=00000005.
- **Leading garbage:** 11 22 CD + 12 bytes → the first two bytes are discarded, one command is issued, and `frame_error` stays 0.
- **Timeout:** `IDLE_TIMEOUT`=16; send CD 01 02, then idle → `frame_error` pulses 16 cycles after byte 02 and no `in_ready`. A following full frame issues correctly.
- **Master busy:** `master_ready`=0 for 10 cycles after the frame completes → `rx_ready`=0 throughout, then a single `in_ready` pulse when `master_ready` rises.
- **Response with backpressure:** `out_en` with status 00000001, address 00000000, data 12345678; `tx_ready` toggling 1/0 → byte sequence DC 00 00 00 01 00 00 00 00 12 34 56 78. `out_ready` returns to 1 only after byte 78 is accepted.
- **Reset mid-frame:** `rst` after 6 body bytes → all outputs reach reset values asynchronously, and the next full frame issues normally.
